// File: rtl/decode_stage.sv
// Registered MIPS decode stage between IF/ID and EX. It decodes one instruction per cycle, uses
// valid/ready on both sides, inserts load-use bubbles and counts them.
module decode_stage #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned EXT_ISA = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DWIDTH-1:0] pc_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        op,
  output logic              ssel,
  output logic [1:0]        wbsel,
  output logic              we_regfile,
  output logic              we_dmem,
  output logic              mem_read,
  output logic [2:0]        jump_type,
  output logic [25:0]       jump_addr,
  output logic [DWIDTH-1:0] imm,
  output logic [4:0]        rs1_id,
  output logic [4:0]        rs2_id,
  output logic [4:0]        rdst_id,
  output logic [DWIDTH-1:0] pc_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluNor = 4'b1100;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNop = 4'b1111;

  localparam logic [2:0] JtNop = 3'd0;
  localparam logic [2:0] JtBeq = 3'd1;
  localparam logic [2:0] JtJal = 3'd2;
  localparam logic [2:0] JtJr  = 3'd3;
  localparam logic [2:0] JtJ   = 3'd4;

  localparam logic [5:0] OpcRtype = 6'b000000;
  localparam logic [5:0] OpcJ     = 6'b000010;
  localparam logic [5:0] OpcJal   = 6'b000011;
  localparam logic [5:0] OpcBeq   = 6'b000100;
  localparam logic [5:0] OpcAddi  = 6'b001000;
  localparam logic [5:0] OpcSlti  = 6'b001010;
  localparam logic [5:0] OpcAndi  = 6'b001100;
  localparam logic [5:0] OpcOri   = 6'b001101;
  localparam logic [5:0] OpcLui   = 6'b001111;
  localparam logic [5:0] OpcLw    = 6'b100011;
  localparam logic [5:0] OpcSw    = 6'b101011;

  localparam logic [5:0] FnJr  = 6'b001000;
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSlt = 6'b101010;

  typedef struct packed {
    logic [3:0]        op;
    logic              ssel;
    logic [1:0]        wbsel;
    logic              we_regfile;
    logic              we_dmem;
    logic              mem_read;
    logic [2:0]        jump_type;
    logic [25:0]       jump_addr;
    logic [DWIDTH-1:0] imm;
    logic [4:0]        rs1_id;
    logic [4:0]        rs2_id;
    logic [4:0]        rdst_id;
    logic [DWIDTH-1:0] pc;
  } payload_t;

  payload_t         pl_d, pl_q, nop_pl;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             uses_rs, uses_rt, hazard;
  logic [31:0]      lui_val;

  wire [5:0] opcode = instr[31:26];
  wire [5:0] funct  = instr[5:0];
  wire [4:0] rs     = instr[25:21];
  wire [4:0] rt     = instr[20:16];
  wire [4:0] rd     = instr[15:11];

  always_comb begin
    nop_pl    = '0;
    nop_pl.op = AluNop;
  end

  assign lui_val = {instr[15:0], 16'b0};

  always_comb begin
    pl_d           = '0;
    pl_d.op        = AluNop;
    pl_d.jump_addr = instr[25:0];
    pl_d.imm       = DWIDTH'($signed(instr[15:0]));
    pl_d.rs1_id    = rs;
    pl_d.rs2_id    = rt;
    pl_d.pc        = pc_in;
    uses_rs        = 1'b0;
    uses_rt        = 1'b0;
    case (opcode)
      OpcRtype: begin
        pl_d.ssel = 1'b1;
        uses_rs   = 1'b1;
        if (funct == FnJr) begin
          pl_d.jump_type = JtJr;
        end else begin
          uses_rt         = 1'b1;
          pl_d.we_regfile = 1'b1;
          pl_d.rdst_id    = rd;
          case (funct)
            FnAdd:   pl_d.op = AluAdd;
            FnSub:   pl_d.op = AluSub;
            FnAnd:   pl_d.op = AluAnd;
            FnOr:    pl_d.op = AluOr;
            FnNor:   pl_d.op = AluNor;
            FnSlt:   pl_d.op = AluSlt;
            default: pl_d.op = AluNop;
          endcase
        end
      end
      OpcAddi, OpcSlti: begin
        pl_d.op         = (opcode == OpcSlti) ? AluSlt : AluAdd;
        pl_d.we_regfile = 1'b1;
        pl_d.rdst_id    = rt;
        uses_rs         = 1'b1;
      end
      OpcLw: begin
        pl_d.op         = AluAdd;
        pl_d.wbsel      = 2'd1;
        pl_d.we_regfile = 1'b1;
        pl_d.mem_read   = 1'b1;
        pl_d.rdst_id    = rt;
        uses_rs         = 1'b1;
      end
      OpcSw: begin
        pl_d.op      = AluAdd;
        pl_d.we_dmem = 1'b1;
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
      end
      OpcBeq: begin
        pl_d.op        = AluSub;
        pl_d.ssel      = 1'b1;
        pl_d.jump_type = JtBeq;
        uses_rs        = 1'b1;
        uses_rt        = 1'b1;
      end
      OpcJ: pl_d.jump_type = JtJ;
      OpcJal: begin
        pl_d.jump_type  = JtJal;
        pl_d.wbsel      = 2'd2;
        pl_d.we_regfile = 1'b1;
        pl_d.rdst_id    = 5'd31;
      end
      OpcAndi, OpcOri: begin
        if (EXT_ISA != 0) begin
          pl_d.op         = (opcode == OpcOri) ? AluOr : AluAnd;
          pl_d.imm        = DWIDTH'(instr[15:0]);
          pl_d.we_regfile = 1'b1;
          pl_d.rdst_id    = rt;
          uses_rs         = 1'b1;
        end
      end
      OpcLui: begin
        if (EXT_ISA != 0) begin
          pl_d.op         = AluAdd;
          pl_d.imm        = DWIDTH'($signed(lui_val));
          pl_d.rs1_id     = 5'd0;
          pl_d.we_regfile = 1'b1;
          pl_d.rdst_id    = rt;
        end
      end
      default: ;
    endcase
  end

  // Load-use check against the instruction currently held in the output register.
  assign hazard = valid_q && pl_q.mem_read && (pl_q.rdst_id != 5'd0) &&
                  ((uses_rs && (pl_q.rdst_id == rs)) || (uses_rt && (pl_q.rdst_id == rt)));

  assign in_ready = !flush && (!valid_q || (out_ready && !hazard));

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pl_q    <= nop_pl;
      cnt_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      pl_q    <= nop_pl;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      pl_q    <= pl_d;
    end else if (valid_q && out_ready && hazard && in_valid) begin
      valid_q <= 1'b0;
      pl_q    <= nop_pl;
      if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid  = valid_q;
  assign op         = pl_q.op;
  assign ssel       = pl_q.ssel;
  assign wbsel      = pl_q.wbsel;
  assign we_regfile = pl_q.we_regfile;
  assign we_dmem    = pl_q.we_dmem;
  assign mem_read   = pl_q.mem_read;
  assign jump_type  = pl_q.jump_type;
  assign jump_addr  = pl_q.jump_addr;
  assign imm        = pl_q.imm;
  assign rs1_id     = pl_q.rs1_id;
  assign rs2_id     = pl_q.rs2_id;
  assign rdst_id    = pl_q.rdst_id;
  assign pc_out     = pl_q.pc;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: hand-written expectations are queued on acceptance and
// compared when EX consumes the output. A second instance checks EXT_ISA = 0.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] instr, pc_in;
  logic        in_ready, out_valid, ssel, we_regfile, we_dmem, mem_read;
  logic [3:0]  op;
  logic [1:0]  wbsel;
  logic [2:0]  jump_type;
  logic [25:0] jump_addr;
  logic [31:0] imm, pc_out;
  logic [4:0]  rs1_id, rs2_id, rdst_id;
  logic [15:0] bubble_cnt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_ssel, b_we_regfile, b_we_dmem, b_mem_read;
  logic [31:0] b_instr;
  logic [3:0]  b_op;
  logic [1:0]  b_wbsel;
  logic [2:0]  b_jump_type;
  logic [25:0] b_jump_addr;
  logic [31:0] b_imm, b_pc_out;
  logic [4:0]  b_rs1_id, b_rs2_id, b_rdst_id;
  logic [15:0] b_bubble_cnt;

  always #5 clk = ~clk;

  decode_stage #(.DWIDTH(32), .EXT_ISA(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .pc_in(pc_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .op(op),
    .ssel(ssel), .wbsel(wbsel), .we_regfile(we_regfile), .we_dmem(we_dmem),
    .mem_read(mem_read), .jump_type(jump_type), .jump_addr(jump_addr), .imm(imm),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rdst_id(rdst_id), .pc_out(pc_out),
    .bubble_cnt(bubble_cnt)
  );

  decode_stage #(.DWIDTH(32), .EXT_ISA(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .instr(b_instr),
    .pc_in(32'h0), .flush(1'b0), .out_valid(b_out_valid), .out_ready(1'b1), .op(b_op),
    .ssel(b_ssel), .wbsel(b_wbsel), .we_regfile(b_we_regfile), .we_dmem(b_we_dmem),
    .mem_read(b_mem_read), .jump_type(b_jump_type), .jump_addr(b_jump_addr), .imm(b_imm),
    .rs1_id(b_rs1_id), .rs2_id(b_rs2_id), .rdst_id(b_rdst_id), .pc_out(b_pc_out),
    .bubble_cnt(b_bubble_cnt)
  );

  typedef struct {
    logic [3:0]  op;
    logic [8:0]  ctl;  // {ssel, wbsel, we_regfile, we_dmem, mem_read, jump_type}
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [25:0] ja;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] o, input logic s, input logic [1:0] wb,
                              input logic wr, input logic wd, input logic mr,
                              input logic [2:0] jt, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [31:0] im);
    exp_t e;
    e.op  = o;
    e.ctl = {s, wb, wr, wd, mr, jt};
    e.rd  = rd;
    e.rs1 = rs1;
    e.imm = im;
    e.pc  = '0;
    e.ja  = '0;
    return e;
  endfunction

  // Present an instruction until accepted; leaves in_valid high on return (posedge + 1).
  task automatic send(input logic [31:0] ins, input logic [31:0] pcv, input exp_t e,
                      input bit push, output int waits);
    exp_t ee;
    ee = e;
    ee.pc = pcv;
    ee.ja = ins[25:0];
    in_valid = 1'b1;
    instr    = ins;
    pc_in    = pcv;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 20) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    if (push && waits <= 20) sb.push_back(ee);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("op", op, e.op);
        check("ctl", {ssel, wbsel, we_regfile, we_dmem, mem_read, jump_type}, e.ctl);
        check("rdst_id", rdst_id, e.rd);
        check("rs1_id", rs1_id, e.rs1);
        check("imm", imm, e.imm);
        check("pc_out", pc_out, e.pc);
        check("jump_addr", jump_addr, e.ja);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; instr = '0; pc_in = '0; flush = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_instr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_op", op, 4'hF);
    check("rst_imm", imm, 0);
    check("rst_rdst", rdst_id, 0);
    check("rst_wbsel", wbsel, 0);
    check("rst_bubble", bubble_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // ADD $3,$1,$2
    send(32'h00221820, 32'h100, mk(4'b0010, 1, 0, 1, 0, 0, 0, 3, 1, 32'h1820), 1, w);
    check("add_wait", w, 0);
    // LW $5,4($1) then dependent ADD $6,$5,$2
    send(32'h8C250004, 32'h104, mk(4'b0010, 0, 1, 1, 0, 1, 0, 5, 1, 32'h4), 1, w);
    send(32'h00A23020, 32'h108, mk(4'b0010, 1, 0, 1, 0, 0, 0, 6, 5, 32'h3020), 1, w);
    check("hazard_wait", w, 1);
    idle(3);
    check("bubble_one", bubble_cnt, 1);

    // LW $0 followed by ADD reading $0: no bubble
    send(32'h8C200000, 32'h10C, mk(4'b0010, 0, 1, 1, 0, 1, 0, 0, 1, 32'h0), 1, w);
    send(32'h00023820, 32'h110, mk(4'b0010, 1, 0, 1, 0, 0, 0, 7, 0, 32'h3820), 1, w);
    check("r0_wait", w, 0);
    idle(3);
    check("bubble_r0", bubble_cnt, 1);

    // SW, BEQ, JR, ORI, LUI back to back
    send(32'hAC220008, 32'h114, mk(4'b0010, 0, 0, 0, 1, 0, 0, 0, 1, 32'h8), 1, w);
    send(32'h1022FFFE, 32'h118, mk(4'b0110, 1, 0, 0, 0, 0, 1, 0, 1, 32'hFFFFFFFE), 1, w);
    send(32'h03E00008, 32'h11C, mk(4'b1111, 1, 0, 0, 0, 0, 3, 0, 31, 32'h8), 1, w);
    send(32'h34228000, 32'h120, mk(4'b0001, 0, 0, 1, 0, 0, 0, 2, 1, 32'h00008000), 1, w);
    send(32'h3C671234, 32'h124, mk(4'b0010, 0, 0, 1, 0, 0, 0, 7, 0, 32'h12340000), 1, w);
    idle(3);

    // Stall: ADDI $4,$0,-1 held with out_ready low
    out_ready = 1'b0;
    send(32'h2004FFFF, 32'h128, mk(4'b0010, 0, 0, 1, 0, 0, 0, 4, 0, 32'hFFFFFFFF), 1, w);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_imm", imm, 32'hFFFFFFFF);
      check("stall_rdst", rdst_id, 4);
      check("stall_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle(2);

    // Flush while holding JAL 0x100 with a valid next instruction
    out_ready = 1'b0;
    send(32'h0C000100, 32'h12C, mk(4'b1111, 0, 2, 1, 0, 0, 2, 31, 0, 32'h100), 0, w);
    instr = 32'h00221820;
    pc_in = 32'h130;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    check("jal_held_jt", jump_type, 2);
    check("jal_held_rdst", rdst_id, 31);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", out_valid, 0);
    check("flush_op", op, 4'hF);
    check("flush_jt", jump_type, 0);
    out_ready = 1'b1;
    idle(3);

    // EXT_ISA = 0: ORI and LUI are unknown opcodes
    b_instr = 32'h34228000;
    b_in_valid = 1'b1;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    @(negedge clk);
    check("b_ori_valid", b_out_valid, 1);
    check("b_ori_op", b_op, 4'hF);
    check("b_ori_we", b_we_regfile, 0);
    b_instr = 32'h3C071234;
    b_in_valid = 1'b1;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    @(negedge clk);
    check("b_lui_valid", b_out_valid, 1);
    check("b_lui_op", b_op, 4'hF);
    check("b_lui_we", b_we_regfile, 0);
    @(posedge clk);
    #1;

    check("sb_empty", sb.size(), 0);
    check("bubble_final", bubble_cnt, 1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
